button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_pkg.sv | 17 +
 rtl/button_conditioner_cell.sv | 65 ++++++
 rtl/button_conditioner.sv | 77 +++++++
 tb/tb_button_conditioner.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared constants for the button conditioner: button indices and the debounce default.
package button_conditioner_pkg;

  // 10 ms at a 50 MHz clock.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

  localparam int unsigned NUM_BTNS         = 3;
  localparam int unsigned BTN_RESET        = 0;
  localparam int unsigned BTN_CLEARA_LOADB = 1;
  localparam int unsigned BTN_RUN          = 2;

  // Counter width able to hold DEBOUNCE_CYCLES-1; a one-cycle debounce still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/button_conditioner_cell.sv
// Per-button conditioning: two-flop synchronizer, stability counter and press-edge detector.
// The raw input is active-low; everything downstream of the first flop is active-high.
module debounce_cell
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DebounceCycles = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_ni,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned     CntW    = cnt_width(DebounceCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic            sync1_q, sync2_q;
  logic            state_q, state_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Synchronizer; reset loads "pressed" so a button held through reset never looks like a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= ~btn_ni;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive mismatching samples; accept on the last one and flag 0->1 acceptances.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != state_q) begin
      if (cnt_q == CntLast) begin
        state_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounced state, counter and registered press pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign level_o = state_q;
  assign press_o = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions three active-low push-buttons and the slider switches for the multiplier front panel.
// Produces debounced levels, single-cycle press strobes (Run gated by Busy, fixed priority) and
// synchronized switches.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Reset_Btn,
  input  logic       ClearA_LoadB,
  input  logic       Run,
  input  logic [7:0] S,
  input  logic       Busy,
  output logic       Reset_SH,
  output logic       ClearA_LoadB_SH,
  output logic       Run_SH,
  output logic [2:0] Pressed,
  output logic [7:0] S_SH
);

  logic [NUM_BTNS-1:0] btn_raw_n;
  logic [NUM_BTNS-1:0] level;
  logic [NUM_BTNS-1:0] press;
  logic [7:0]          s_sync1_q;

  // Gather the raw buttons by their package index.
  always_comb begin
    btn_raw_n                   = '1;
    btn_raw_n[BTN_RESET]        = Reset_Btn;
    btn_raw_n[BTN_CLEARA_LOADB] = ClearA_LoadB;
    btn_raw_n[BTN_RUN]          = Run;
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_cell
    debounce_cell #(
      .DebounceCycles(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk_i  (Clk),
      .rst_i  (Reset),
      .btn_ni (btn_raw_n[i]),
      .level_o(level[i]),
      .press_o(press[i])
    );
  end

  assign Pressed = level;

  // Switch synchronizer; no debouncing on the sliders.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s_sync1_q <= '0;
      S_SH      <= '0;
    end else begin
      s_sync1_q <= S;
      S_SH      <= s_sync1_q;
    end
  end

  // Resolve coincident presses; lower-priority strobes and a busy-time Run are dropped, not held.
  always_comb begin
    Reset_SH        = 1'b0;
    ClearA_LoadB_SH = 1'b0;
    Run_SH          = 1'b0;
    if (!Reset) begin
      if (press[BTN_RESET]) begin
        Reset_SH = 1'b1;
      end else if (press[BTN_CLEARA_LOADB]) begin
        ClearA_LoadB_SH = 1'b1;
      end else if (press[BTN_RUN] && !Busy) begin
        Run_SH = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4 and a run-length reference model.
module tb_button_conditioner;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       reset, rstb_n, clr_n, run_n, busy;
  logic [7:0] s_in;
  logic       reset_sh, clr_sh, run_sh;
  logic [2:0] pressed;
  logic [7:0] s_sh;

  int n_vec = 0;
  int n_bad = 0;
  int cnt_rst = 0;
  int cnt_clr = 0;
  int cnt_run = 0;
  bit chk_en = 1'b0;

  // Reference model: raw-sample history, debounced state, run length of the synced level.
  logic [2:0] m_h0, m_h1, m_st, m_last, m_pls;
  int         m_run [3];
  logic [7:0] m_s [$];

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .Clk            (clk),
    .Reset          (reset),
    .Reset_Btn      (rstb_n),
    .ClearA_LoadB   (clr_n),
    .Run            (run_n),
    .S              (s_in),
    .Busy           (busy),
    .Reset_SH       (reset_sh),
    .ClearA_LoadB_SH(clr_sh),
    .Run_SH         (run_sh),
    .Pressed        (pressed),
    .S_SH           (s_sh)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A button flips once its synced level has differed from the debounced state for N cycles.
  task automatic model_step();
    logic [2:0] rp;
    logic       s;
    rp = {~run_n, ~clr_n, ~rstb_n};
    if (reset) begin
      m_h0   = 3'b111;
      m_h1   = 3'b111;
      m_st   = 3'b111;
      m_last = 3'b111;
      m_pls  = 3'b000;
      for (int b = 0; b < 3; b++) m_run[b] = 0;
      m_s.delete();
      m_s.push_back(8'h00);
      m_s.push_back(8'h00);
    end else begin
      for (int b = 0; b < 3; b++) begin
        s = m_h1[b];
        if (s == m_last[b]) m_run[b]++;
        else m_run[b] = 1;
        m_last[b] = s;
        m_pls[b]  = 1'b0;
        if (s != m_st[b] && m_run[b] >= N) begin
          m_st[b]  = s;
          m_pls[b] = s;
        end
      end
      m_h1 = m_h0;
      m_h0 = rp;
      m_s.push_back(s_in);
      void'(m_s.pop_front());
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  initial begin
    logic er, ec, eu;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        er = m_pls[0] & ~reset;
        ec = m_pls[1] & ~m_pls[0] & ~reset;
        eu = m_pls[2] & ~m_pls[0] & ~m_pls[1] & ~busy & ~reset;
        chk("pulses", {29'd0, reset_sh, clr_sh, run_sh}, {29'd0, er, ec, eu});
        chk("pressed", {29'd0, pressed}, {29'd0, m_st});
        chk("s_sh", {24'd0, s_sh}, {24'd0, m_s[0]});
        cnt_rst += int'(reset_sh);
        cnt_clr += int'(clr_sh);
        cnt_run += int'(run_sh);
      end
    end
  end

  initial begin
    reset  = 1'b1;
    rstb_n = 1'b1;
    clr_n  = 1'b1;
    run_n  = 1'b1;
    busy   = 1'b0;
    s_in   = 8'hFF;
    wait_edges(1);
    chk_en = 1'b1;
    wait_edges(1);
    chk("reset_pressed", {29'd0, pressed}, 32'h7);
    chk("reset_s_sh", {24'd0, s_sh}, 32'h0);
    chk("reset_pulses", {29'd0, reset_sh, clr_sh, run_sh}, 32'h0);

    // Released at reset: debounce to 0 without pulses.
    reset = 1'b0;
    wait_edges(10);
    chk("release_pressed", {29'd0, pressed}, 32'h0);
    chk("release_no_pulse", cnt_rst + cnt_clr + cnt_run, 0);

    // Clean Run press: strobe exactly in the cycle after edge N+2.
    run_n = 1'b0;
    wait_edges(5);
    chk("run_edge5", {31'd0, run_sh}, 32'h0);
    wait_edges(1);
    chk("run_edge6", {31'd0, run_sh}, 32'h1);
    chk("run_level", {31'd0, pressed[2]}, 32'h1);
    wait_edges(1);
    chk("run_edge7", {31'd0, run_sh}, 32'h0);
    wait_edges(5);
    chk("run_held_count", cnt_run, 1);
    chk("run_held_level", {31'd0, pressed[2]}, 32'h1);
    run_n = 1'b1;
    wait_edges(8);
    chk("run_release_level", {31'd0, pressed[2]}, 32'h0);
    chk("run_release_count", cnt_run, 1);

    // Glitches of N-1 samples never register.
    repeat (5) begin
      run_n = 1'b0;
      wait_edges(3);
      run_n = 1'b1;
      wait_edges(3);
    end
    wait_edges(4);
    chk("glitch_count", cnt_run, 1);
    chk("glitch_level", {31'd0, pressed[2]}, 32'h0);

    // Busy exactly in the acceptance cycle: strobe dropped and not replayed.
    run_n = 1'b0;
    wait_edges(5);
    busy = 1'b1;
    wait_edges(1);
    chk("busy_pulse", {31'd0, run_sh}, 32'h0);
    chk("busy_level", {31'd0, pressed[2]}, 32'h1);
    wait_edges(1);
    busy = 1'b0;
    wait_edges(4);
    chk("busy_not_queued", cnt_run, 1);
    run_n = 1'b1;
    wait_edges(8);
    run_n = 1'b0;
    wait_edges(10);
    chk("after_busy_count", cnt_run, 2);
    run_n = 1'b1;
    wait_edges(8);

    // ClearA_LoadB beats Run on the same edge.
    run_n = 1'b0;
    clr_n = 1'b0;
    wait_edges(10);
    chk("prio_clr_count", cnt_clr, 1);
    chk("prio_run_count", cnt_run, 2);
    chk("prio_levels", {29'd0, pressed}, 32'h6);
    run_n = 1'b1;
    clr_n = 1'b1;
    wait_edges(8);

    // Reset_Btn beats ClearA_LoadB on the same edge.
    rstb_n = 1'b0;
    clr_n  = 1'b0;
    wait_edges(10);
    chk("prio_rst_count", cnt_rst, 1);
    chk("prio_clr_dropped", cnt_clr, 1);
    rstb_n = 1'b1;
    clr_n  = 1'b1;
    wait_edges(8);

    // Reset_Btn held through Reset: no strobe until released and pressed again.
    rstb_n = 1'b0;
    wait_edges(2);
    reset = 1'b1;
    wait_edges(2);
    chk("reset2_s_sh", {24'd0, s_sh}, 32'h0);
    chk("reset2_pressed", {29'd0, pressed}, 32'h7);
    reset = 1'b0;
    wait_edges(10);
    chk("held_no_pulse", cnt_rst, 1);
    chk("held_levels", {29'd0, pressed}, 32'h1);
    rstb_n = 1'b1;
    wait_edges(8);
    chk("held_released", {29'd0, pressed}, 32'h0);
    rstb_n = 1'b0;
    wait_edges(10);
    chk("repress_count", cnt_rst, 2);
    rstb_n = 1'b1;
    wait_edges(8);

    // Reset mid-debounce drops the partial count; the held button then gives no strobe.
    clr_n = 1'b0;
    wait_edges(4);
    reset = 1'b1;
    wait_edges(1);
    reset = 1'b0;
    wait_edges(10);
    chk("mid_reset_count", cnt_clr, 1);
    chk("mid_reset_levels", {29'd0, pressed}, 32'h2);
    clr_n = 1'b1;
    wait_edges(8);

    // Switch latency: two edges.
    s_in = 8'h3C;
    wait_edges(3);
    s_in = 8'hA5;
    wait_edges(1);
    chk("s_k1", {24'd0, s_sh}, 32'h3C);
    wait_edges(1);
    chk("s_k2", {24'd0, s_sh}, 32'hA5);
    wait_edges(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
